seg_scan_decoder: RTL and testbench

Receive-side companion to the multiplexed four-digit seven-segment display driver. It samples the driver's digit-select and segment lines and waits for each scanned digit to settle. It decodes each segment pattern back to a BCD nibble and reports a completed four-digit frame as a single 16-bit word. It is used for loopback self-test of the display path and as a monitor on the board's display bus.

---
 rtl/seg_scan_if.sv | 20 ++
 rtl/seg_scan_decoder.sv | 101 ++++++++++
 tb/tb_seg_scan_decoder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// seg_scan_if: scanned display bus plus decoded frame/status returned by the monitor
interface seg_scan_if;
  logic [3:0]  scan_digits;
  logic [7:0]  scan_segments;
  logic        clear;
  logic [15:0] value;
  logic [3:0]  dp_out;
  logic [3:0]  blank;
  logic        frame_valid;
  logic        bad_pattern;
  logic        bad_select;
  modport master (
    output scan_digits, scan_segments, clear,
    input  value, dp_out, blank, frame_valid, bad_pattern, bad_select
  );
  modport slave (
    input  scan_digits, scan_segments, clear,
    output value, dp_out, blank, frame_valid, bad_pattern, bad_select
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: debounces a multiplexed 7-seg scan and reassembles four-digit BCD frames
module seg_scan_decoder #(
  parameter int SETTLE = 4
) (
  input logic      clk,
  input logic      rst,
  seg_scan_if.slave bus_io
);
  localparam logic [3:0] SET    = 4'(SETTLE);
  localparam logic [3:0] SET_M1 = 4'(SETTLE - 1);
  logic [11:0] raw, in_q;
  logic [3:0]  cnt_q, cnt_d, sel, seen_q, seen_d, wr, nib;
  logic        cap, one_hot, multi_hot, done, pat_blank, pat_bad;
  logic [15:0] sh_val_q, sh_val_d, value_q, value_d;
  logic [3:0]  sh_dp_q, sh_dp_d, sh_bl_q, sh_bl_d, dp_q, dp_d, bl_q, bl_d;
  logic        fv_q, bp_q, bp_d, bs_q, bs_d;
  assign raw       = {bus_io.scan_digits, bus_io.scan_segments};
  assign sel       = in_q[11:8];
  assign one_hot   = sel != 4'h0 && (sel & (sel - 4'h1)) == 4'h0;
  assign multi_hot = sel != 4'h0 && !one_hot;
  assign cap       = raw == in_q && cnt_q == SET_M1;
  assign done      = seen_q == 4'hF;
  assign wr        = cap && one_hot ? sel : 4'h0;
  // Dwell length of the current bus value; saturation makes capture fire once per dwell
  always_comb cnt_d = raw != in_q ? 4'd0 : cnt_q == SET ? cnt_q : cnt_q + 4'd1;
  // Active-low A-G pattern to BCD; blank maps to F, anything unknown to E
  always_comb begin
    nib = 4'hE;
    pat_blank = 1'b0;
    pat_bad = 1'b0;
    case (in_q[6:0])
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h10: nib = 4'h9;
      7'h7F: begin nib = 4'hF; pat_blank = 1'b1; end
      default: pat_bad = 1'b1;
    endcase
  end
  // Shadow slot writes, frame hand-off once all digits are seen, sticky error flags
  always_comb begin
    sh_val_d = sh_val_q;
    sh_dp_d = sh_dp_q;
    sh_bl_d = sh_bl_q;
    for (int i = 0; i < 4; i++) begin
      if (wr[i]) begin
        sh_val_d[4*i +: 4] = nib;
        sh_dp_d[i] = ~in_q[7];
        sh_bl_d[i] = pat_blank;
      end
    end
    seen_d  = (done ? 4'h0 : seen_q) | wr;
    value_d = done ? sh_val_q : value_q;
    dp_d    = done ? sh_dp_q : dp_q;
    bl_d    = done ? sh_bl_q : bl_q;
    bp_d    = (bp_q & ~bus_io.clear) | (cap & one_hot & pat_bad);
    bs_d    = (bs_q & ~bus_io.clear) | (cap & multi_hot);
  end
  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q <= '0;
      cnt_q <= '0;
      seen_q <= '0;
      sh_val_q <= '0;
      sh_dp_q <= '0;
      sh_bl_q <= '0;
      value_q <= '0;
      dp_q <= '0;
      bl_q <= '0;
      fv_q <= 1'b0;
      bp_q <= 1'b0;
      bs_q <= 1'b0;
    end else begin
      in_q <= raw;
      cnt_q <= cnt_d;
      seen_q <= seen_d;
      sh_val_q <= sh_val_d;
      sh_dp_q <= sh_dp_d;
      sh_bl_q <= sh_bl_d;
      value_q <= value_d;
      dp_q <= dp_d;
      bl_q <= bl_d;
      fv_q <= done;
      bp_q <= bp_d;
      bs_q <= bs_d;
    end
  end
  assign bus_io.value       = value_q;
  assign bus_io.dp_out      = dp_q;
  assign bus_io.blank       = bl_q;
  assign bus_io.frame_valid = fv_q;
  assign bus_io.bad_pattern = bp_q;
  assign bus_io.bad_select  = bs_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scans checked against a run-length/frame model every cycle
module tb_seg_scan_decoder;
  localparam int S = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  seg_scan_if bus();
  seg_scan_decoder #(.SETTLE(S)) dut (.clk(clk), .rst(rst), .bus_io(bus));
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0, fv_cyc = -1, fv_count = 0, k_last = 0;
  logic [15:0] m_val;
  logic [3:0]  m_dp, m_bl, m_seen, s_dp, s_bl;
  logic [3:0]  s_nib [4];
  logic        m_fv, m_bp, m_bs, pend;
  logic [11:0] last;
  int          run;
  logic [6:0]  tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a capture happens on the edge where the same bus value has been seen S+1 edges in a row
  always @(posedge clk) begin : model
    logic [11:0] raw;
    logic [3:0]  nib;
    logic        bl, bad;
    int          idx;
    cyc++;
    if (rst) begin
      m_val = 0; m_dp = 0; m_bl = 0; m_fv = 0; m_bp = 0; m_bs = 0;
      m_seen = 0; s_dp = 0; s_bl = 0; pend = 0; last = 0; run = 1;
      for (int i = 0; i < 4; i++) s_nib[i] = 0;
    end else begin
      m_fv = pend;
      if (pend) begin
        for (int i = 0; i < 4; i++) m_val[4*i +: 4] = s_nib[i];
        m_dp = s_dp; m_bl = s_bl; m_seen = 0; pend = 0;
      end
      if (bus.clear) begin m_bp = 0; m_bs = 0; end
      raw = {bus.scan_digits, bus.scan_segments};
      run = (raw == last) ? (run < S + 2 ? run + 1 : run) : 1;
      last = raw;
      if (run == S + 1) begin
        if ($countones(raw[11:8]) == 1) begin
          idx = 0;
          for (int i = 0; i < 4; i++) if (raw[8+i]) idx = i;
          nib = 4'hE; bl = 0; bad = 1;
          for (int d = 0; d < 10; d++) if (raw[6:0] == tbl[d]) begin nib = 4'(d); bad = 0; end
          if (raw[6:0] == 7'h7F) begin nib = 4'hF; bl = 1; bad = 0; end
          s_nib[idx] = nib; s_dp[idx] = ~raw[7]; s_bl[idx] = bl; m_seen[idx] = 1'b1;
          if (bad) m_bp = 1;
          if (m_seen == 4'hF) pend = 1;
        end else if (raw[11:8] != 4'h0) m_bs = 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("value", 32'(bus.value), 32'(m_val));
    check("dp_out", 32'(bus.dp_out), 32'(m_dp));
    check("blank", 32'(bus.blank), 32'(m_bl));
    check("frame_valid", 32'(bus.frame_valid), 32'(m_fv));
    check("bad_pattern", 32'(bus.bad_pattern), 32'(m_bp));
    check("bad_select", 32'(bus.bad_select), 32'(m_bs));
    if (bus.frame_valid) begin fv_count++; fv_cyc = cyc; end
  end

  // Present one bus value for n edges; called at a falling edge
  task automatic hold(input logic [3:0] d, input logic [7:0] s, input int n);
    bus.scan_digits = d;
    bus.scan_segments = s;
    k_last = cyc + 1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int kk;
    bus.scan_digits = 4'h0; bus.scan_segments = 8'hFF; bus.clear = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_value", 32'(bus.value), 32'h0);
    check("reset_flags", 32'({bus.frame_valid, bus.bad_pattern, bus.bad_select}), 32'h0);
    repeat (2) begin
      hold(4'b0001, 8'hB0, 13); hold(4'b0010, 8'hB0, 13);
      hold(4'b0100, 8'h82, 13); hold(4'b1000, 8'hB0, 13);
    end
    check("scan_frames", fv_count, 2);
    check("scan_value", 32'(bus.value), 32'h3633);
    check("scan_dp_blank", 32'({bus.dp_out, bus.blank}), 32'h0);
    check("scan_errors", 32'({bus.bad_pattern, bus.bad_select}), 32'h0);
    hold(4'b0010, 8'hF9, 8); hold(4'b0100, 8'hA4, 8); hold(4'b1000, 8'h99, 8);
    hold(4'b0001, 8'h80, S); hold(4'b0000, 8'hFF, 10);
    check("short_dwell", fv_count, 2);
    hold(4'b0001, 8'h80, S + 1);
    kk = k_last;
    hold(4'b0000, 8'hFF, 10);
    check("fv_latency", fv_cyc, kk + S + 1);
    check("dwell_value", 32'(bus.value), 32'h4218);
    hold(4'b0001, 8'hC0, 8); hold(4'b0010, 8'hF8, 8); hold(4'b0100, 8'h55, 8);
    hold(4'b1000, 8'h90, 8); hold(4'b0000, 8'hFF, 8);
    check("bad_value", 32'(bus.value), 32'h9E70);
    check("bad_dp", 32'(bus.dp_out), 32'h4);
    hold(4'b0000, 8'hFF, 10);
    check("bp_sticky", 32'(bus.bad_pattern), 32'h1);
    bus.clear = 1'b1; hold(4'b0000, 8'hFF, 1); bus.clear = 1'b0; hold(4'b0000, 8'hFF, 2);
    check("bp_cleared", 32'(bus.bad_pattern), 32'h0);
    hold(4'b0001, 8'hC0, 8); hold(4'b0010, 8'hF8, 8); hold(4'b1000, 8'h90, 8);
    hold(4'b0100, 8'h55, S); bus.clear = 1'b1; hold(4'b0100, 8'h55, 1); bus.clear = 1'b0;
    hold(4'b0000, 8'hFF, 4);
    check("clear_vs_error", 32'(bus.bad_pattern), 32'h1);
    check("bad_frames", fv_count, 5);
    bus.clear = 1'b1; hold(4'b0000, 8'hFF, 1); bus.clear = 1'b0;
    hold(4'b0000, 8'hC0, 10);
    check("idle_select", 32'(bus.bad_select), 32'h0);
    hold(4'b0110, 8'hC0, 10); hold(4'b0000, 8'hFF, 2);
    check("multi_select", 32'(bus.bad_select), 32'h1);
    check("multi_no_frame", fv_count, 5);
    bus.clear = 1'b1; hold(4'b0000, 8'hFF, 1); bus.clear = 1'b0;
    hold(4'b1000, 8'hFF, 8); hold(4'b0010, 8'h92, 8); hold(4'b0010, 8'hF8, 8);
    hold(4'b0001, 8'hC0, 8);
    check("no_early_frame", fv_count, 5);
    hold(4'b0100, 8'h82, 8); hold(4'b0000, 8'hFF, 4);
    check("overwrite_frames", fv_count, 6);
    check("overwrite_value", 32'(bus.value), 32'hF670);
    check("overwrite_blank", 32'(bus.blank), 32'h8);
    hold(4'b0001, 8'hF9, 8); hold(4'b0010, 8'hA4, 8); hold(4'b0100, 8'hB0, 8);
    bus.scan_digits = 4'h0; bus.scan_segments = 8'hFF; rst = 1'b1;
    #1;
    check("rst_value", 32'(bus.value), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold(4'b0001, 8'h92, 8); hold(4'b0010, 8'h82, 8); hold(4'b0100, 8'hF8, 8);
    check("rst_no_early", fv_count, 6);
    hold(4'b1000, 8'h80, 8);
    kk = k_last;
    hold(4'b0000, 8'hFF, 4);
    check("rst_frames", fv_count, 7);
    check("rst_fv_time", fv_cyc, kk + S + 1);
    check("rst_value_new", 32'(bus.value), 32'h8765);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
